matrix_reader: RTL
==================

# matrix_reader

Synthesizable read-side counterpart of the matrix file writer. On `start`, it sweeps an n×n matrix of 32-bit words out of a synchronous single-port memory. It presents each word, tagged with its (i, j) index, to a downstream consumer over a `value_stb`/`value_ack` handshake. It sits between the operand matrix RAMs and the multiplier datapath, and it replaces behavioural file loading in synthesized builds.

## Interface
- `n`, default 8: matrix dimension; legal range is n ≥ 2. Index width is IW = $clog2(n).
- `W`, default 32: word width.

- `clk` input, 1 bit: sole clock; all logic on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: begin a matrix sweep; sampled only in IDLE or DONE.
- `mem_rd` output, 1 bit: memory read enable.
- `mem_i` output, IW bits: memory row address.
- `mem_j` output, IW bits: memory column address.
- `mem_data` input, W bits: read data, valid exactly one cycle after `mem_rd`.
- `value` output, W bits: presented word.
- `i` output, IW bits: row index of `value`.
- `j` output, IW bits: column index of `value`.
- `last` output, 1 bit: high with `value_stb` for the final element of the sweep.
- `value_stb` output, 1 bit: `value`, `i`, `j` and `last` are valid.
- `value_ack` input, 1 bit: consumer accepts the element.
- `busy` output, 1 bit: a sweep is in progress.
- `done` output, 1 bit: the sweep is complete.

## Operation
- **States:** IDLE, FETCH, CAPTURE, PRESENT, DONE. Encoding is 3 bits; unused codes go to IDLE.
- **IDLE:**
  - With `start` = 1, clear the row and column counters to 0 and go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH:** drive `mem_rd` = 1 with `mem_i`/`mem_j` set to the counters, then go to CAPTURE. `mem_rd` is 0 in every other state.
- **CAPTURE:** register `mem_data` into `value` and the counters into `i`/`j`. Set `last` when both counters equal n−1. Go to PRESENT.
- **PRESENT:**
  - Hold `value_stb` = 1. `value`, `i`, `j` and `last` stay stable until the acknowledge.
  - On `value_ack` = 1, drop `value_stb` next cycle.
  - If `last` was set, go to DONE.
  - Otherwise advance the counters and go to FETCH.
- **Counter order:** row-major. The column counter increments; on n−1 it wraps to 0 and the row counter increments.
- **DONE:**
  - `done` = 1, held as a level.
  - On `start` = 1, clear `done`, clear the counters and go to FETCH, same as from IDLE.
- **`busy`:** 1 in FETCH, CAPTURE and PRESENT; 0 otherwise.
- **Ignored inputs:**
  - `start` is ignored while `busy`.
  - `value_ack` is ignored while `value_stb` = 0.
- **Reset:** asserting `rst_n` low in any state, including mid-sweep, immediately forces IDLE. All outputs go to 0 (`value`, `i`, `j`, `last`, `value_stb`, `mem_rd`, `mem_i`, `mem_j`, `busy`, `done`). A partially delivered sweep is abandoned; there is no resume.

## Timing
- Count `start` sampled high at edge 0.
  - `mem_rd` is high in cycle 1.
  - `mem_data` is captured at edge 2.
  - `value_stb` rises in cycle 3.
- Per element: acknowledge at edge k gives `value_stb` low in cycle k+1, `mem_rd` in cycle k+1, and the next `value_stb` in cycle k+3. Minimum is 3 cycles per element, so a full sweep takes at least 3·n² + 1 cycles from `start` to `done`.
- `value_ack` high in the first cycle of `value_stb` counts; no wait state is required.
- `done` rises the cycle after the acknowledge of the `last` element.
- Memory contract: read latency is exactly 1. `mem_data` is not sampled outside CAPTURE.

## Configuration
- **`MATRIX_READER_TRANSPOSE_EN`**
  - Defined: sweep column-major. The row counter increments fastest and wraps into the column counter, so the consumer receives the transpose order. `i`/`j` still report true memory coordinates.
  - Undefined: row-major, as described in Operation.
  - `last` is (n−1, n−1) in both modes.

## Test plan
- **Full sweep:** reset, memory holds word i·16+j, n=4, `value_ack` tied high, pulse `start`.
  - Required: 16 elements in order 0x00, 0x01, … 0x33 with matching i/j.
  - `last` only on 0x33.
  - `done` rises 49 cycles after `start`.
- **Backpressure:** hold `value_ack` low for 5 cycles on element (1,2). Required: `value_stb`, `value` = 0x12, i=1, j=2 all stable for those cycles, with no `mem_rd` pulses during the stall.
- **Ignored start:** pulse `start` while `busy` at element (0,3). Required: the sweep is unaffected and exactly 16 elements are delivered.
- **Restart from DONE:** after `done`, pulse `start` again. Required: `done` clears the next cycle and the sweep repeats from (0,0).
- **Mid-sweep reset:** assert `rst_n` low during PRESENT of element (2,1). Required: all outputs read 0 immediately. After release, with no `start`, the block stays idle with `value_stb` = 0.
- **Transpose mode:** with `MATRIX_READER_TRANSPOSE_EN` defined, n=4. Required: order 0x00, 0x10, 0x20, 0x30, 0x01, … 0x33, with `last` on 0x33.

Source files
------------

// File: rtl/matrix_reader.sv
// matrix_reader: sweeps an n x n matrix of W-bit words out of a 1-cycle-latency RAM
// and hands each (value, i, j, last) to a consumer over a stb/ack handshake.
// Define MATRIX_READER_TRANSPOSE_EN for a column-major sweep.
module matrix_reader #(
  parameter int unsigned n  = 8,
  parameter int unsigned W  = 32,
  localparam int unsigned IW = $clog2(n)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          mem_rd,
  output logic [IW-1:0] mem_i,
  output logic [IW-1:0] mem_j,
  input  logic [W-1:0]  mem_data,
  output logic [W-1:0]  value,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic          last,
  output logic          value_stb,
  input  logic          value_ack,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [IW-1:0] LAST_IDX = IW'(n - 1);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;
  logic [W-1:0]  value_d;
  logic [IW-1:0] i_d, j_d;
  logic          last_d;

  // The address counters are the memory address; they only move outside FETCH.
  assign mem_i = row_q;
  assign mem_j = col_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counter and element-capture logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    value_d = value;
    i_d     = i;
    j_d     = j;
    last_d  = last;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        value_d = mem_data;
        i_d     = row_q;
        j_d     = col_q;
        last_d  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (value_ack) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
`ifdef MATRIX_READER_TRANSPOSE_EN
            if (row_q == LAST_IDX) begin
              row_d = '0;
              col_d = col_q + IW'(1);
            end else begin
              row_d = row_q + IW'(1);
            end
`else
            if (col_q == LAST_IDX) begin
              col_d = '0;
              row_d = row_q + IW'(1);
            end else begin
              col_d = col_q + IW'(1);
            end
`endif
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      col_q     <= '0;
      value     <= '0;
      i         <= '0;
      j         <= '0;
      last      <= 1'b0;
      mem_rd    <= 1'b0;
      value_stb <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      value     <= value_d;
      i         <= i_d;
      j         <= j_d;
      last      <= last_d;
      mem_rd    <= (state_d == S_FETCH);
      value_stb <= (state_d == S_PRESENT);
      busy      <= (state_d == S_FETCH) || (state_d == S_CAPTURE) || (state_d == S_PRESENT);
      done      <= (state_d == S_DONE);
    end
  end

endmodule
